// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate response checker: reference-function
// encodings, the run-state enum and the expected-value function.
package gate_chk_pkg;

    localparam int unsigned OP_AND  = 0;
    localparam int unsigned OP_OR   = 1;
    localparam int unsigned OP_XOR  = 2;
    localparam int unsigned OP_NAND = 3;
    localparam int unsigned OP_NOR  = 4;
    localparam int unsigned OP_XNOR = 5;

    // Widest gate the reference function is written for
    localparam int unsigned MAX_IN = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // Reduce the low n_in bits of vec with the selected function; reserved ops yield 0
    function automatic logic gate_eval(input logic [MAX_IN-1:0] vec,
                                       input int unsigned       n_in,
                                       input int unsigned       op);
        logic v_and;
        logic v_or;
        logic v_xor;
        v_and = 1'b1;
        v_or  = 1'b0;
        v_xor = 1'b0;
        for (int i = 0; i < int'(MAX_IN); i++) begin
            if (i < int'(n_in)) begin
                v_and = v_and & vec[i];
                v_or  = v_or  | vec[i];
                v_xor = v_xor ^ vec[i];
            end
        end
        case (op)
            OP_AND:  return v_and;
            OP_OR:   return v_or;
            OP_XOR:  return v_xor;
            OP_NAND: return ~v_and;
            OP_NOR:  return ~v_or;
            OP_XNOR: return ~v_xor;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference gate: produces the expected output for an input vector.
module gate_ref_model
    import gate_chk_pkg::*;
#(
    parameter int unsigned N_IN = 2,
    parameter int unsigned OP   = 0
) (
    input  logic [N_IN-1:0] i_in_vec,
    output logic            o_y_exp
);

    logic [MAX_IN-1:0] w_vec;

    // Zero-extend so the shared function sees a fixed-width vector
    always_comb begin
        w_vec   = MAX_IN'(i_in_vec);
        o_y_exp = gate_eval(w_vec, N_IN, OP);
    end

endmodule

// File: rtl/gate_response_checker.sv
// Judges a gate under test: compares each strobed sample against the reference
// function and accumulates pass/error/sample counts, input coverage and the
// first failing vector. Results freeze in DONE until the next START.
module gate_response_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned N_IN        = 2,
    parameter int unsigned OP          = 0,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned NUM_SAMPLES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_valid,
    input  logic [N_IN-1:0]       i_in_vec,
    input  logic                  i_y_obs,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [CNT_W-1:0]      o_pass_cnt,
    output logic [CNT_W-1:0]      o_err_cnt,
    output logic [CNT_W-1:0]      o_smp_cnt,
    output logic [(2**N_IN)-1:0]  o_cov_map,
    output logic                  o_covered,
    output logic                  o_fail_seen,
    output logic [N_IN:0]         o_fail_vec
);

    localparam int unsigned COV_W = 2**N_IN;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t               r_state;
    logic                 r_busy;
    logic                 r_done;
    logic [CNT_W-1:0]     r_pass_cnt;
    logic [CNT_W-1:0]     r_err_cnt;
    logic [CNT_W-1:0]     r_smp_cnt;
    logic [COV_W-1:0]     r_cov_map;
    logic                 r_fail_seen;
    logic [N_IN:0]        r_fail_vec;

    logic                 w_y_exp;
    logic                 w_accept;
    logic                 w_match;
    logic [CNT_W-1:0]     w_pass_inc;
    logic [CNT_W-1:0]     w_err_inc;
    logic [CNT_W-1:0]     w_smp_inc;
    logic                 w_auto_fin;

    gate_ref_model #(
        .N_IN (N_IN),
        .OP   (OP)
    ) u_ref (
        .i_in_vec (i_in_vec),
        .o_y_exp  (w_y_exp)
    );

    // Sample qualification and saturating next-count values
    always_comb begin
        w_accept   = (r_state == ST_RUN) && i_valid && !i_start;
        w_match    = (i_y_obs == w_y_exp);
        w_pass_inc = (&r_pass_cnt) ? r_pass_cnt : r_pass_cnt + CNT_ONE;
        w_err_inc  = (&r_err_cnt)  ? r_err_cnt  : r_err_cnt  + CNT_ONE;
        w_smp_inc  = (&r_smp_cnt)  ? r_smp_cnt  : r_smp_cnt  + CNT_ONE;
        // Compared in 33 bits so a NUM_SAMPLES beyond the counter range never matches
        w_auto_fin = (NUM_SAMPLES != 0) && (33'(w_smp_inc) == 33'(NUM_SAMPLES));
    end

    // Run-control FSM with registered BUSY/DONE
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_stop || (w_accept && w_auto_fin)) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result accumulation: cleared on START, updated on accepted samples only
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_start) begin
            r_pass_cnt  <= '0;
            r_err_cnt   <= '0;
            r_smp_cnt   <= '0;
            r_cov_map   <= '0;
            r_fail_seen <= 1'b0;
            r_fail_vec  <= '0;
        end else if (w_accept) begin
            r_smp_cnt           <= w_smp_inc;
            r_cov_map[i_in_vec] <= 1'b1;
            if (w_match) begin
                r_pass_cnt <= w_pass_inc;
            end else begin
                r_err_cnt <= w_err_inc;
                if (!r_fail_seen) begin
                    r_fail_seen <= 1'b1;
                    r_fail_vec  <= {i_y_obs, i_in_vec};
                end
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass_cnt  = r_pass_cnt;
    assign o_err_cnt   = r_err_cnt;
    assign o_smp_cnt   = r_smp_cnt;
    assign o_cov_map   = r_cov_map;
    assign o_covered   = &r_cov_map;
    assign o_fail_seen = r_fail_seen;
    assign o_fail_vec  = r_fail_vec;

endmodule

// File: tb/tb_gate_response_checker.sv
// Self-checking bench: reference-function table over all ops, plus directed
// run sequences on three checker instances sharing one stimulus bus.
module tb_gate_response_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       valid;
    logic [1:0] in_vec;
    logic       y_obs;
    logic [2:0] ref_vec;

    int n_tests;
    int n_fail;

    // dut_a: NUM_SAMPLES=4 auto-finish; dut_b: unlimited; dut_c: 2-bit counters
    logic        a_busy, a_done, a_covered, a_fail_seen;
    logic [15:0] a_pass, a_err, a_smp;
    logic [3:0]  a_cov;
    logic [2:0]  a_fvec;
    logic        b_busy, b_done, b_covered, b_fail_seen;
    logic [15:0] b_pass, b_err, b_smp;
    logic [3:0]  b_cov;
    logic [2:0]  b_fvec;
    logic        c_busy, c_done, c_covered, c_fail_seen;
    logic [1:0]  c_pass, c_err, c_smp;
    logic [3:0]  c_cov;
    logic [2:0]  c_fvec;
    logic [6:0]  ref_exp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    gate_response_checker #(.N_IN(2), .OP(0), .CNT_W(16), .NUM_SAMPLES(4)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_valid(valid),
        .i_in_vec(in_vec), .i_y_obs(y_obs), .o_busy(a_busy), .o_done(a_done),
        .o_pass_cnt(a_pass), .o_err_cnt(a_err), .o_smp_cnt(a_smp), .o_cov_map(a_cov),
        .o_covered(a_covered), .o_fail_seen(a_fail_seen), .o_fail_vec(a_fvec)
    );

    gate_response_checker #(.N_IN(2), .OP(0), .CNT_W(16), .NUM_SAMPLES(0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_valid(valid),
        .i_in_vec(in_vec), .i_y_obs(y_obs), .o_busy(b_busy), .o_done(b_done),
        .o_pass_cnt(b_pass), .o_err_cnt(b_err), .o_smp_cnt(b_smp), .o_cov_map(b_cov),
        .o_covered(b_covered), .o_fail_seen(b_fail_seen), .o_fail_vec(b_fvec)
    );

    gate_response_checker #(.N_IN(2), .OP(0), .CNT_W(2), .NUM_SAMPLES(0)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop), .i_valid(valid),
        .i_in_vec(in_vec), .i_y_obs(y_obs), .o_busy(c_busy), .o_done(c_done),
        .o_pass_cnt(c_pass), .o_err_cnt(c_err), .o_smp_cnt(c_smp), .o_cov_map(c_cov),
        .o_covered(c_covered), .o_fail_seen(c_fail_seen), .o_fail_vec(c_fvec)
    );

    // One 3-input reference per op (op 6 is reserved and must read 0)
    for (genvar g = 0; g < 7; g++) begin : g_ref
        gate_ref_model #(.N_IN(3), .OP(g)) u_ref (
            .i_in_vec (ref_vec),
            .o_y_exp  (ref_exp[g])
        );
    end

    typedef struct {
        logic [2:0] vec;
        logic [6:0] exp;   // bit k = expected output of op k
    } ref_rec_t;

    typedef struct {
        logic [1:0] vec;
        logic       y;
    } smp_rec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [1:0] v, input logic y, input logic stp);
        valid  = 1'b1;
        in_vec = v;
        y_obs  = y;
        stop   = stp;
        step();
        valid  = 1'b0;
        stop   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    ref_rec_t rtab[5];
    smp_rec_t good[4];
    smp_rec_t bad[4];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; valid = 1'b0;
        in_vec = 2'b00; y_obs = 1'b0; ref_vec = 3'b000;

        // Ops: bit0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 reserved
        rtab[0] = '{vec: 3'b000, exp: 7'b0111000};
        rtab[1] = '{vec: 3'b011, exp: 7'b0101010};
        rtab[2] = '{vec: 3'b111, exp: 7'b0000111};
        rtab[3] = '{vec: 3'b100, exp: 7'b0001110};
        rtab[4] = '{vec: 3'b110, exp: 7'b0101010};
        good[0] = '{vec: 2'b00, y: 1'b0};
        good[1] = '{vec: 2'b01, y: 1'b0};
        good[2] = '{vec: 2'b10, y: 1'b0};
        good[3] = '{vec: 2'b11, y: 1'b1};
        bad[0]  = '{vec: 2'b00, y: 1'b0};
        bad[1]  = '{vec: 2'b01, y: 1'b1};
        bad[2]  = '{vec: 2'b10, y: 1'b0};
        bad[3]  = '{vec: 2'b11, y: 1'b0};

        for (int i = 0; i < 5; i++) begin
            ref_vec = rtab[i].vec;
            #1;
            chk($sformatf("ref_vec%0d", i), 32'(ref_exp), 32'(rtab[i].exp));
        end

        // Reset state
        step();
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_done", 32'(a_done), 0);
        chk("rst_smp", 32'(a_smp), 0);
        chk("rst_fvec", 32'(a_fvec), 0);
        rst_n = 1'b1;
        sample(2'b11, 1'b1, 1'b0);
        chk("idle_ignores_valid", 32'(a_smp), 0);

        // Test 1: clean AND sweep, auto-finish after 4 samples
        do_start();
        chk("t1_busy", 32'(a_busy), 1);
        for (int i = 0; i < 4; i++) begin
            sample(good[i].vec, good[i].y, 1'b0);
            if (i == 2) chk("t1_busy_before_last", 32'(a_busy), 1);
        end
        chk("t1_pass", 32'(a_pass), 4);
        chk("t1_err", 32'(a_err), 0);
        chk("t1_cov", 32'(a_cov), 32'hf);
        chk("t1_covered", 32'(a_covered), 1);
        chk("t1_done", 32'(a_done), 1);
        chk("t1_not_busy", 32'(a_busy), 0);
        sample(2'b00, 1'b1, 1'b0);
        chk("t1_done_ignores_valid", 32'(a_err), 0);

        // Test 2: two mismatches, first one captured
        do_start();
        for (int i = 0; i < 4; i++) sample(bad[i].vec, bad[i].y, 1'b0);
        chk("t2_err", 32'(a_err), 2);
        chk("t2_pass", 32'(a_pass), 2);
        chk("t2_fail_seen", 32'(a_fail_seen), 1);
        chk("t2_fail_vec", 32'(a_fvec), 32'b101);

        // Test 3: unlimited run, STOP coincident with a sample
        do_start();
        sample(2'b11, 1'b1, 1'b0);
        sample(2'b11, 1'b1, 1'b0);
        sample(2'b00, 1'b0, 1'b0);
        chk("t3_busy_before_stop", 32'(b_busy), 1);
        sample(2'b00, 1'b0, 1'b1);
        chk("t3_smp", 32'(b_smp), 4);
        chk("t3_cov", 32'(b_cov), 32'b1001);
        chk("t3_covered", 32'(b_covered), 0);
        chk("t3_done", 32'(b_done), 1);

        // Test 5: 2-bit counters saturate at 3
        do_start();
        for (int i = 0; i < 5; i++) sample(2'b11, 1'b1, 1'b0);
        chk("t5_pass_sat", 32'(c_pass), 3);
        chk("t5_smp_sat", 32'(c_smp), 3);
        chk("t5_still_busy", 32'(c_busy), 1);

        // Test 4: reset mid-run clears everything; valid ignored until START
        do_start();
        sample(2'b01, 1'b1, 1'b0);
        sample(2'b10, 1'b0, 1'b0);
        chk("t4_pre_smp", 32'(b_smp), 2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t4_busy", 32'(b_busy), 0);
        chk("t4_smp", 32'(b_smp), 0);
        chk("t4_err", 32'(b_err), 0);
        chk("t4_cov", 32'(b_cov), 0);
        chk("t4_fail_seen", 32'(b_fail_seen), 0);
        sample(2'b11, 1'b1, 1'b0);
        sample(2'b11, 1'b1, 1'b0);
        chk("t4_ignored", 32'(b_smp), 0);

        // Test 6: START in DONE with VALID high
        do_start();
        for (int i = 0; i < 4; i++) sample(good[i].vec, good[i].y, 1'b0);
        chk("t6_in_done", 32'(a_done), 1);
        valid = 1'b1; in_vec = 2'b11; y_obs = 1'b0;
        do_start();
        valid = 1'b0;
        chk("t6_smp_cleared", 32'(a_smp), 0);
        chk("t6_err_cleared", 32'(a_err), 0);
        chk("t6_cov_cleared", 32'(a_cov), 0);
        chk("t6_busy", 32'(a_busy), 1);
        chk("t6_done_low", 32'(a_done), 0);
        sample(2'b10, 1'b1, 1'b0);
        chk("t6_next_counted", 32'(a_err), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
